// File: rtl/uart_alu_pkg.sv
// Shared opcodes, FSM encoding and opcode validation for the UART/ALU frame sequencer.
package uart_alu_pkg;

   localparam int OP_W = 6;

   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

   localparam int STATE_W = 3;

   // TX_STAT/WAIT_STAT are only reachable when the status byte is enabled.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_B    = 3'd1,
      ST_WAIT_OP   = 3'd2,
      ST_EXEC      = 3'd3,
      ST_TX_RES    = 3'd4,
      ST_WAIT_TX   = 3'd5,
      ST_TX_STAT   = 3'd6,
      ST_WAIT_STAT = 3'd7
   } state_t;

   function automatic logic opcode_valid(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOR, OP_SRA, OP_SRL: opcode_valid = 1'b1;
         default:                        opcode_valid = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte timeout: reloads on each accepted byte and counts down while enabled.
// TIMEOUT_CYC = 0 disables expiry entirely.
module frame_timeout_counter #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_load,
   input  logic i_enable,
   output logic o_expire
);

   localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt <= '0;
      end else if (i_load) begin
         cnt <= LOAD_VAL;
      end else if (i_clear) begin
         cnt <= '0;
      end else if (i_enable && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Expiry means TIMEOUT_CYC idle cycles have elapsed since the last load.
   assign o_expire = (TIMEOUT_CYC != 0) && i_enable && (cnt == '0);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Frame controller between UART RX/TX and the combinational ALU: A, B, opcode in; result out.
// Optional status byte after the result is enabled by defining UART_ALU_STATUS_TX_EN.
module uart_alu_sequencer
   import uart_alu_pkg::*;
#(
   parameter int              DBIT        = 8,
   parameter int              NB_OP       = 6,
   parameter int              TIMEOUT_CYC = 100000,
   parameter logic [DBIT-1:0] ERR_CODE    = DBIT'(8'hFF)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_rx_done_tick,
   input  logic [DBIT-1:0]  i_rx_data,
   input  logic [DBIT-1:0]  i_alu_result,
   input  logic             i_tx_done_tick,
   output logic [DBIT-1:0]  o_data_a,
   output logic [DBIT-1:0]  o_data_b,
   output logic [NB_OP-1:0] o_operation,
   output logic             o_tx_start,
   output logic [DBIT-1:0]  o_tx_data,
   output logic             o_busy,
   output logic             o_frame_err,
   output logic             o_overrun,
   output state_t           o_state
);

   // Handshake: i_rx_done_tick is a one-cycle "byte valid" strobe with no back-pressure,
   // so bytes arriving while busy are dropped and flagged. o_tx_start is a one-cycle
   // request; o_tx_data is held until the matching i_tx_done_tick acknowledges it.

   state_t          state, state_nxt;
   logic            invalid_q;
   logic            op_ok;
   logic            in_wait;
   logic            to_expire;
   logic            to_load;
   logic            ld_a, ld_b, ld_op, ld_res;
   logic            frame_err_nxt;
   logic [DBIT-1:0] res_byte;
`ifdef UART_ALU_STATUS_TX_EN
   logic            zero_q;
   logic            ld_stat;
`endif

   assign op_ok    = (i_rx_data[DBIT-1:NB_OP] == '0)
                     && opcode_valid(OP_W'(i_rx_data[NB_OP-1:0]));
   assign in_wait  = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
   assign res_byte = invalid_q ? ERR_CODE : i_alu_result;
   assign to_load  = i_rx_done_tick && ((state == ST_IDLE) || (state == ST_WAIT_B));

   frame_timeout_counter #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (!in_wait),
      .i_load   (to_load),
      .i_enable (in_wait),
      .o_expire (to_expire)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      ld_a          = 1'b0;
      ld_b          = 1'b0;
      ld_op         = 1'b0;
      ld_res        = 1'b0;
      frame_err_nxt = 1'b0;
`ifdef UART_ALU_STATUS_TX_EN
      ld_stat       = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (i_rx_done_tick) begin
               ld_a      = 1'b1;
               state_nxt = ST_WAIT_B;
            end
         end
         ST_WAIT_B: begin
            // A byte landing on the expiry cycle still wins over the timeout.
            if (i_rx_done_tick) begin
               ld_b      = 1'b1;
               state_nxt = ST_WAIT_OP;
            end else if (to_expire) begin
               frame_err_nxt = 1'b1;
               state_nxt     = ST_IDLE;
            end
         end
         ST_WAIT_OP: begin
            if (i_rx_done_tick) begin
               ld_op     = 1'b1;
               state_nxt = ST_EXEC;
            end else if (to_expire) begin
               frame_err_nxt = 1'b1;
               state_nxt     = ST_IDLE;
            end
         end
         ST_EXEC: begin
            ld_res    = 1'b1;
            state_nxt = ST_TX_RES;
         end
         ST_TX_RES: begin
            state_nxt = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (i_tx_done_tick) begin
`ifdef UART_ALU_STATUS_TX_EN
               ld_stat   = 1'b1;
               state_nxt = ST_TX_STAT;
`else
               state_nxt = ST_IDLE;
`endif
            end
         end
`ifdef UART_ALU_STATUS_TX_EN
         ST_TX_STAT: begin
            state_nxt = ST_WAIT_STAT;
         end
         ST_WAIT_STAT: begin
            if (i_tx_done_tick) begin
               state_nxt = ST_IDLE;
            end
         end
`endif
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_data_a    <= '0;
         o_data_b    <= '0;
         o_operation <= '0;
         o_tx_data   <= '0;
         invalid_q   <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
`ifdef UART_ALU_STATUS_TX_EN
         zero_q      <= 1'b0;
`endif
      end else begin
         if (ld_a) begin
            o_data_a <= i_rx_data;
         end
         if (ld_b) begin
            o_data_b <= i_rx_data;
         end
         // An invalid opcode leaves the previous operation on the ALU.
         if (ld_op) begin
            invalid_q <= !op_ok;
            if (op_ok) begin
               o_operation <= i_rx_data[NB_OP-1:0];
            end
         end
         if (ld_res) begin
            o_tx_data <= res_byte;
`ifdef UART_ALU_STATUS_TX_EN
            zero_q    <= (res_byte == '0);
`endif
         end
`ifdef UART_ALU_STATUS_TX_EN
         if (ld_stat) begin
            o_tx_data <= {{(DBIT-2){1'b0}}, invalid_q, zero_q};
         end
`endif
         o_frame_err <= frame_err_nxt;
         o_overrun   <= i_rx_done_tick && o_busy;
      end
   end

   assign o_busy = (state == ST_EXEC) || (state == ST_TX_RES) || (state == ST_WAIT_TX)
`ifdef UART_ALU_STATUS_TX_EN
                   || (state == ST_TX_STAT) || (state == ST_WAIT_STAT)
`endif
                   ;

   assign o_tx_start = (state == ST_TX_RES)
`ifdef UART_ALU_STATUS_TX_EN
                       || (state == ST_TX_STAT)
`endif
                       ;

   assign o_state = state;

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Frame-level controller between the UART RX/TX pair and the combinational ALU.
- Collects a 3-byte frame (operand A, operand B, opcode) and validates the opcode.
- Drives the ALU operand/opcode registers, captures the result and runs the TX start/done handshake.
- Adds inter-byte timeout, overrun detection and a busy flag.

Parameters:
- DBIT, 8, data/operand width in bits.
- NB_OP, 6, opcode width in bits.
- TIMEOUT_CYC, 100000, max idle cycles between frame bytes; 0 disables the timeout.
- ERR_CODE, 8'hFF, byte transmitted in place of the result when the opcode is invalid.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_done_tick  in  1  one-cycle pulse; i_rx_data valid.
- i_rx_data  in  DBIT  received byte.
- i_alu_result  in  DBIT  combinational ALU output.
- i_tx_done_tick  in  1  one-cycle pulse; UART TX finished the byte.
- o_data_a  out  DBIT  ALU operand A (registered).
- o_data_b  out  DBIT  ALU operand B (registered).
- o_operation  out  NB_OP  ALU opcode (registered).
- o_tx_start  out  1  one-cycle pulse starting TX of o_tx_data.
- o_tx_data  out  DBIT  byte to transmit, held stable until i_tx_done_tick.
- o_busy  out  1  high in EXEC, TX_RES, WAIT_TX (and TX_STAT, WAIT_STAT if enabled).
- o_frame_err  out  1  one-cycle pulse on inter-byte timeout.
- o_overrun  out  1  one-cycle pulse when a byte arrives while busy.

Behaviour:
- Reset (asynchronous, i_reset=0): all outputs 0, state IDLE, timeout counter 0.
- States: IDLE -> WAIT_B -> WAIT_OP -> EXEC -> TX_RES -> WAIT_TX -> IDLE.
- IDLE: on i_rx_done_tick, o_data_a <= i_rx_data; go to WAIT_B.
- WAIT_B: on tick, o_data_b <= i_rx_data; go to WAIT_OP.
- WAIT_OP: on tick, validate the byte.
  - Valid means bits [DBIT-1:NB_OP] are zero and bits [NB_OP-1:0] match an opcode in the package list.
  - Valid: o_operation <= i_rx_data[NB_OP-1:0]. Invalid: o_operation holds its previous value and the invalid flag is set.
  - Go to EXEC.
- EXEC (1 cycle, lets the ALU settle on the registered operands): o_tx_data <= invalid ? ERR_CODE : i_alu_result; go to TX_RES.
- TX_RES: o_tx_start = 1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: hold o_tx_data; on i_tx_done_tick go to IDLE.
- Latency: opcode tick at cycle N -> EXEC at N+1, o_tx_start high at N+2.
- Timeout:
  - The counter runs only in WAIT_B/WAIT_OP and clears on every accepted byte.
  - When the count reaches TIMEOUT_CYC with no tick: go to IDLE and pulse o_frame_err. o_data_a/o_data_b keep their values.
  - A tick in the same cycle as expiry: the byte is accepted and no error is raised.
  - No timeout in IDLE or in the busy states.
  - Counter width is $clog2(TIMEOUT_CYC+1), minimum 1.
- Overrun: an i_rx_done_tick while o_busy=1 is dropped and pulses o_overrun. State and data are unchanged. The next frame starts only after returning to IDLE.
- An i_tx_done_tick outside the WAIT states is ignored.
- Reset mid-frame or mid-TX: immediate return to IDLE with all outputs 0. A pending TX done is ignored afterwards.

Optional Feature:
- Macro: UART_ALU_STATUS_TX_EN.
- Defined:
  - After WAIT_TX, go to TX_STAT: o_tx_data <= {{(DBIT-2){1'b0}}, invalid, zero}, where zero = (result byte == 0). Pulse o_tx_start.
  - Then WAIT_STAT; on i_tx_done_tick go to IDLE.
  - o_busy is high through WAIT_STAT.
- Undefined: the frame ends after the result byte; TX_STAT and WAIT_STAT do not exist.

Decomposition:
- Package uart_alu_pkg:
  - Opcode localparams: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010.
  - State encoding localparams.
  - Opcode-valid function.
- One sub-module, frame_timeout_counter: load/clear/enable inputs, expire output.

Test Plan:
- Frame 0x05, 0x03, 0x20 with a model ADD ALU -> o_data_a=0x05, o_data_b=0x03, o_operation=0x20; o_tx_start pulse 2 cycles after the 3rd tick with o_tx_data=0x08; o_busy is deasserted after i_tx_done_tick.
- Frame 0x10, 0x01, 0x3F (invalid opcode) -> o_tx_data=0xFF, o_operation unchanged. With UART_ALU_STATUS_TX_EN, the second byte is 0x02.
- TIMEOUT_CYC=16: send 0xAA, then idle 16 cycles -> o_frame_err pulse, state IDLE. The next byte 0x07 is taken as A.
- Byte 0x55 injected during WAIT_TX -> o_overrun pulse; o_data_a unchanged; the next frame after done is processed normally.
- Assert i_reset low mid-WAIT_OP (async, between clock edges) -> all outputs 0 immediately. A following full frame 0x02, 0x02, 0x22 (SUB) -> o_tx_data=0x00; status byte 0x01 when the macro is defined.
- A tick coinciding with timeout expiry in WAIT_B -> byte accepted as B, no o_frame_err.
